// File: rtl/bsg_dlatch_capture_fifo.sv
// Small FIFO that captures data from an upstream transparent latch on the rising edge of clk_i.
// Offers made while full are discarded and tallied in a saturating drop counter.
module bsg_dlatch_capture_fifo #(
    parameter int width_p      = 32,
    parameter int els_p        = 2,
    parameter int drop_width_p = 8,
    localparam int ptr_w       = $clog2(els_p),
    localparam int cnt_w       = ptr_w + 1
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic [width_p-1:0]      data_i,
    input  logic                    v_i,
    output logic                    ready_o,
    output logic [width_p-1:0]      data_o,
    output logic                    v_o,
    input  logic                    yumi_i,
    output logic [cnt_w-1:0]        count_o,
    output logic [drop_width_p-1:0] drop_count_o
);

    function automatic logic [drop_width_p-1:0] sat_inc(input logic [drop_width_p-1:0] val);
        return (&val) ? val : val + drop_width_p'(1);
    endfunction

    logic [width_p-1:0] mem [els_p];
    logic [ptr_w-1:0]   wptr, rptr;
    logic [cnt_w-1:0]   count;
    logic [drop_width_p-1:0] drops;
    logic enq, deq, drop;

    // Handshake decisions depend only on registered occupancy, never on yumi_i.
    assign ready_o      = (count != cnt_w'(els_p));
    assign v_o          = (count != '0);
    assign data_o       = mem[rptr];
    assign count_o      = count;
    assign drop_count_o = drops;

    assign enq  = v_i & ready_o;
    assign deq  = yumi_i & v_o;
    assign drop = v_i & ~ready_o;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            drops <= '0;
        end else begin
            if (enq)  wptr  <= wptr + ptr_w'(1);
            if (deq)  rptr  <= rptr + ptr_w'(1);
            if (drop) drops <= sat_inc(drops);
            case ({enq, deq})
                2'b10:   count <= count + cnt_w'(1);
                2'b01:   count <= count - cnt_w'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage is data only: no reset, written solely at the tail on enqueue.
    always_ff @(posedge clk_i) begin
        if (enq) mem[wptr] <= data_i;
    end

    yumi_needs_valid: assert property (@(posedge clk_i) disable iff (reset_i) !(yumi_i && !v_o))
        else $warning("protocol violation: yumi_i asserted while fifo empty");

endmodule

// File: tb/tb_bsg_dlatch_capture_fifo.sv
// Directed bench for bsg_dlatch_capture_fifo with a queue-based reference model
// compared on every falling edge, plus literal expectations at key points.
module tb_bsg_dlatch_capture_fifo;

    localparam int W    = 32;
    localparam int ELS  = 2;
    localparam int DW   = 8;
    localparam int CW   = $clog2(ELS) + 1;
    localparam int DMAX = (1 << DW) - 1;

    logic          clk = 1'b0;
    logic          reset_i;
    logic [W-1:0]  data_i;
    logic          v_i;
    logic          ready_o;
    logic [W-1:0]  data_o;
    logic          v_o;
    logic          yumi_i;
    logic [CW-1:0] count_o;
    logic [DW-1:0] drop_count_o;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] q [$];
    int           m_drops = 0;

    bsg_dlatch_capture_fifo #(.width_p(W), .els_p(ELS), .drop_width_p(DW)) dut (
        .clk_i        (clk),
        .reset_i      (reset_i),
        .data_i       (data_i),
        .v_i          (v_i),
        .ready_o      (ready_o),
        .data_o       (data_o),
        .v_o          (v_o),
        .yumi_i       (yumi_i),
        .count_o      (count_o),
        .drop_count_o (drop_count_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference behaviour for one rising edge, from the occupancy rules alone.
    task automatic model_edge(input logic v, input logic [W-1:0] d, input logic y);
        bit room;
        room = (q.size() < ELS);
        if (y && q.size() > 0) void'(q.pop_front());
        if (v && room) q.push_back(d);
        if (v && !room && m_drops < DMAX) m_drops++;
    endtask

    task automatic cyc(input logic v, input logic [W-1:0] d, input logic y);
        v_i    = v;
        data_i = d;
        yumi_i = y;
        @(posedge clk);
        if (!reset_i) model_edge(v, d, y);
        @(negedge clk);
    endtask

    task automatic model_reset();
        q.delete();
        m_drops = 0;
    endtask

    always @(negedge clk) begin
        check("count", count_o, q.size());
        check("v_o", v_o, q.size() != 0);
        check("ready", ready_o, q.size() != ELS);
        check("drops", drop_count_o, m_drops);
        if (q.size() > 0) check("data", data_o, q[0]);
    end

    initial begin
        reset_i = 1'b1;
        v_i     = 1'b0;
        yumi_i  = 1'b0;
        data_i  = '0;
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_count", count_o, 0);
        check("rst_v", v_o, 0);
        check("rst_ready", ready_o, 1);
        check("rst_drops", drop_count_o, 0);
        reset_i = 1'b0;

        // single enqueue, visible the following cycle
        cyc(1'b1, 32'hDEADBEEF, 1'b0);
        check("s1_v", v_o, 1);
        check("s1_data", data_o, 32'hDEADBEEF);
        check("s1_count", count_o, 1);
        check("s1_ready", ready_o, 1);

        // fill and overflow by one
        cyc(1'b0, '0, 1'b1);
        cyc(1'b1, 32'h1, 1'b0);
        cyc(1'b1, 32'h2, 1'b0);
        cyc(1'b1, 32'h3, 1'b0);
        check("s2_count", count_o, 2);
        check("s2_ready", ready_o, 0);
        check("s2_drops", drop_count_o, 1);
        check("s2_data", data_o, 32'h1);

        // drop counter saturation
        for (int i = 0; i < 299; i++) cyc(1'b1, 32'(i), 1'b0);
        check("sat_drops", drop_count_o, 8'hFF);
        cyc(1'b1, 32'h44, 1'b0);
        check("sat_hold", drop_count_o, 8'hFF);
        check("sat_head", data_o, 32'h1);

        // offer while full with a dequeue: offer is still a drop
        cyc(1'b1, 32'h66, 1'b1);
        check("full_deq_count", count_o, 1);
        check("full_deq_head", data_o, 32'h2);

        // drain, then yumi while empty changes nothing
        cyc(1'b0, '0, 1'b1);
        cyc(1'b0, '0, 1'b1);
        check("empty_yumi_count", count_o, 0);
        check("empty_yumi_ready", ready_o, 1);

        // steady-state enqueue+dequeue at count 1 across pointer wraps
        cyc(1'b1, 32'h55, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 32'hA0 + 32'(i), 1'b1);
            check("pass_count", count_o, 1);
            check("pass_data", data_o, 32'hA0 + 32'(i));
        end

        // asynchronous reset between edges with two entries held
        cyc(1'b1, 32'h77, 1'b0);
        check("pre_rst_count", count_o, 2);
        v_i = 1'b0;
        #2;
        reset_i = 1'b1;
        model_reset();
        #1;
        check("arst_v", v_o, 0);
        check("arst_count", count_o, 0);
        check("arst_ready", ready_o, 1);
        check("arst_drops", drop_count_o, 0);
        @(posedge clk);
        @(negedge clk);
        reset_i = 1'b0;
        cyc(1'b1, 32'h99, 1'b0);
        check("post_rst_count", count_o, 1);
        check("post_rst_data", data_o, 32'h99);

        // mixed traffic, consumer only takes when the model holds data
        for (int i = 0; i < 24; i++) begin
            cyc((i % 3) != 0, 32'hC000 + 32'(i), (i % 2 == 1) && (q.size() > 0));
        end
        cyc(1'b0, '0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
